rifl_rx_buffer: RTL and testbench

RIFL_RX_BUFFER -- requirements
Module: rifl_rx_buffer

---
 rtl/rifl_rx_buf_pkg.sv | 7 +
 rtl/rifl_rx_buf_ram.sv | 26 ++
 rtl/rifl_rx_buffer.sv | 106 ++++++++++
 tb/tb_rifl_rx_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rifl_rx_buf_pkg.sv
// rifl_rx_buf_pkg: shared widths and write-side FSM state for the RIFL rx buffer
package rifl_rx_buf_pkg;
    localparam int DATA_W  = 112;
    localparam int KEEP_W  = 14;
    localparam int ENTRY_W = DATA_W + KEEP_W + 1;
    typedef enum logic [1:0] {IDLE, RECV, DROP} wr_state_t;
endpackage

// File: rtl/rifl_rx_buf_ram.sv
// rifl_rx_buf_ram: simple dual-port RAM, DEPTH x ENTRY_W, sync write, sync read
// Ports: clk, rst_n (clears only the read register); we/wa/wd write port;
//        re/ra read port, rd registered read data (holds when re=0).
module rifl_rx_buf_ram import rifl_rx_buf_pkg::*; #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      wa,
    input  logic [ENTRY_W-1:0] wd,
    input  logic               re,
    input  logic [AW-1:0]      ra,
    output logic [ENTRY_W-1:0] rd
);
    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;

    // The read register doubles as the output stage, so it holds while stalled
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rd <= '0;
        else if (re) rd <= mem[ra];
endmodule

// File: rtl/rifl_rx_buffer.sv
// rifl_rx_buffer: store-and-forward packet FIFO behind the RIFL rx stream
// Ports: clk, rst_n (async, active-low); s_axis_* input beats (no ready);
//        m_axis_* buffered committed beats with ready; pause_req registered
//        occupancy >= PAUSE_THRESH; overflow one-cycle drop pulse;
//        drop_cnt saturating dropped-packet count (RIFL_RX_BUF_STATS_EN only).
module rifl_rx_buffer import rifl_rx_buf_pkg::*; #(
    parameter int DEPTH        = 64,
    parameter int PAUSE_THRESH = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              pause_req,
    output logic              overflow
`ifdef RIFL_RX_BUF_STATS_EN
    ,
    output logic [31:0]       drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_USED = (AW+1)'(DEPTH);
    localparam logic [AW:0] PAUSE_P   = (AW+1)'(PAUSE_THRESH);

    wr_state_t          state, state_n;
    logic [AW:0]        wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, rd_ptr, rd_ptr_n;
    logic [AW:0]        used, used_n;
    logic               full, we, drop, load;
    logic [ENTRY_W-1:0] rd_data;

    assign used   = wr_ptr - rd_ptr;
    assign full   = used == FULL_USED;
    assign used_n = wr_ptr_n - rd_ptr_n;
    // Reload the output stage when it is empty or being consumed
    assign load     = (!m_axis_tvalid || m_axis_tready) && (rd_ptr != commit_ptr);
    assign rd_ptr_n = load ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        state_n      = state;
        wr_ptr_n     = wr_ptr;
        commit_ptr_n = commit_ptr;
        we           = 1'b0;
        drop         = 1'b0;
        if (s_axis_tvalid) begin
            if (state == DROP) begin
                state_n = s_axis_tlast ? IDLE : DROP;
            end else if (full) begin
                // Throw away the partial packet written so far
                drop     = 1'b1;
                wr_ptr_n = commit_ptr;
                state_n  = s_axis_tlast ? IDLE : DROP;
            end else begin
                we           = 1'b1;
                wr_ptr_n     = wr_ptr + 1'b1;
                commit_ptr_n = s_axis_tlast ? wr_ptr + 1'b1 : commit_ptr;
                state_n      = s_axis_tlast ? IDLE : RECV;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            rd_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
            pause_req     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_n;
            wr_ptr        <= wr_ptr_n;
            commit_ptr    <= commit_ptr_n;
            rd_ptr        <= rd_ptr_n;
            m_axis_tvalid <= load || (m_axis_tvalid && !m_axis_tready);
            pause_req     <= used_n >= PAUSE_P;
            overflow      <= drop;
        end
    end

`ifdef RIFL_RX_BUF_STATS_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) drop_cnt <= '0;
        else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
`endif

    rifl_rx_buf_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .wa   (wr_ptr[AW-1:0]),
        .wd   ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .re   (load),
        .ra   (rd_ptr[AW-1:0]),
        .rd   (rd_data)
    );

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_data;
endmodule

// File: tb/tb_rifl_rx_buffer.sv
// tb_rifl_rx_buffer: self-checking bench for rifl_rx_buffer (DEPTH=16, PAUSE_THRESH=12)
module tb_rifl_rx_buffer;
    import rifl_rx_buf_pkg::*;
    localparam int D  = 16;
    localparam int PT = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [DATA_W-1:0] s_tdata = '0;
    logic [KEEP_W-1:0] s_tkeep = '0;
    logic s_tlast = 1'b0, s_tvalid = 1'b0, m_tready = 1'b0;
    logic [DATA_W-1:0] m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic m_tlast, m_tvalid, pause_req, overflow;
`ifdef RIFL_RX_BUF_STATS_EN
    logic [31:0] drop_cnt;
`endif
    logic [ENTRY_W-1:0] m_beat;
    assign m_beat = {m_tlast, m_tkeep, m_tdata};

    rifl_rx_buffer #(.DEPTH(D), .PAUSE_THRESH(PT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .pause_req(pause_req), .overflow(overflow)
`ifdef RIFL_RX_BUF_STATS_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic iv; logic il; logic [KEEP_W-1:0] ik; logic ir;
        logic ev; logic el; logic [KEEP_W-1:0] ek; int ed;
    } vec_t;
    vec_t tv [10];

    int tests = 0, fails = 0, ovf_cnt = 0, rcvd = 0;
    bit mon_en = 0, hold_v = 0;
    logic [ENTRY_W-1:0] hold_beat;
    logic [ENTRY_W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(int i);
        return {4{28'(i * 1234567 + 7654321)}};
    endfunction

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, 16'($urandom)};
    endfunction

    // Scoreboard: every handshake must match the oldest expected beat; a stalled beat must not change
    task automatic monitor();
        if (hold_v && rst_n) chk("hold_stable", {m_tvalid, m_beat}, {1'b1, hold_beat});
        if (m_tvalid && m_tready && rst_n) begin
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("beat_data", m_beat, exp_q.pop_front());
            rcvd++;
        end
        hold_v = m_tvalid && !m_tready && rst_n;
        hold_beat = m_beat;
    endtask

    task automatic tick();
        @(negedge clk);
        if (overflow) ovf_cnt++;
        if (mon_en) monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1; ovf_cnt = 0; rcvd = 0;
    endtask

    task automatic send_pkt(int n, bit push);
        for (int i = 0; i < n; i++) begin
            s_tvalid = 1'b1; s_tlast = (i == n - 1);
            s_tkeep = 14'($urandom); s_tdata = rnd_data();
            if (push) exp_q.push_back({s_tlast, s_tkeep, s_tdata});
            tick();
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic drain(int budget);
        m_tready = 1'b1; s_tvalid = 1'b0;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        chk("drain_left", exp_q.size(), 0);
        repeat (4) tick();
    endtask

    initial begin
        // in: valid last keep ready | out after the edge: valid last keep data-index
        tv = '{
            '{1'b1, 1'b0, 14'h3FFF, 1'b1, 1'b0, 1'b0, 14'h0000, 0},
            '{1'b1, 1'b0, 14'h0FFF, 1'b1, 1'b0, 1'b0, 14'h0000, 0},
            '{1'b1, 1'b0, 14'h3FFF, 1'b1, 1'b0, 1'b0, 14'h0000, 0},
            '{1'b1, 1'b1, 14'h007F, 1'b1, 1'b0, 1'b0, 14'h0000, 0},
            '{1'b0, 1'b0, 14'h0000, 1'b1, 1'b1, 1'b0, 14'h3FFF, 0},
            '{1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 14'h3FFF, 0},
            '{1'b0, 1'b0, 14'h0000, 1'b1, 1'b1, 1'b0, 14'h0FFF, 1},
            '{1'b0, 1'b0, 14'h0000, 1'b1, 1'b1, 1'b0, 14'h3FFF, 2},
            '{1'b0, 1'b0, 14'h0000, 1'b1, 1'b1, 1'b1, 14'h007F, 3},
            '{1'b0, 1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 14'h0000, 0}
        };

        // Reset values
        repeat (2) tick();
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_beat", m_beat, 0);
        chk("rst_pause", pause_req, 0);
        chk("rst_overflow", overflow, 0);
`ifdef RIFL_RX_BUF_STATS_EN
        chk("rst_drop_cnt", drop_cnt, 0);
`endif
        rst_n = 1'b1;
        tick();

        // 4-beat packet: visible two cycles after tlast, in order, with one stall
        for (int i = 0; i < 10; i++) begin
            s_tvalid = tv[i].iv; s_tlast = tv[i].il; s_tkeep = tv[i].ik;
            s_tdata = tv[i].iv ? pat(i) : '0; m_tready = tv[i].ir;
            tick();
            chk($sformatf("vec%0d_valid", i), m_tvalid, tv[i].ev);
            if (tv[i].ev) chk($sformatf("vec%0d_beat", i), m_beat, {tv[i].el, tv[i].ek, pat(tv[i].ed)});
        end

        // 20-beat packet into 16 entries: overflow on beat 17, nothing released
        mon_en = 1; m_tready = 1'b1; ovf_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            s_tvalid = 1'b1; s_tlast = (k == 20); s_tkeep = 14'($urandom); s_tdata = rnd_data();
            tick();
            chk($sformatf("long_ovf_b%0d", k), overflow, k == 17);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        repeat (3) tick();
        chk("long_no_output", m_tvalid, 0);
        chk("long_ovf_cnt", ovf_cnt, 1);
`ifdef RIFL_RX_BUF_STATS_EN
        chk("long_drop_cnt", drop_cnt, 1);
`endif
        send_pkt(2, 1);
        drain(20);

        // Three 6-beat packets, no reads: the third cannot fit in 16 entries
        do_reset();
        send_pkt(6, 1);
        send_pkt(6, 1);
        send_pkt(6, 0);
        repeat (2) tick();
        chk("three_ovf_cnt", ovf_cnt, 1);
        chk("three_tvalid", m_tvalid, 1);
`ifdef RIFL_RX_BUF_STATS_EN
        chk("three_drop_cnt", drop_cnt, 1);
`endif
        drain(40);
        chk("three_beats_out", rcvd, 12);

        // pause_req follows occupancy one cycle after the write
        do_reset();
        for (int k = 1; k <= PT + 1; k++) begin
            s_tvalid = 1'b1; s_tlast = (k == PT + 1); s_tkeep = 14'($urandom); s_tdata = rnd_data();
            exp_q.push_back({s_tlast, s_tkeep, s_tdata});
            tick();
            chk($sformatf("pause_b%0d", k), pause_req, k >= PT);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        repeat (3) tick();
        chk("pause_held", pause_req, 1);
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        tick();
        chk("pause_released", pause_req, 0);
        drain(40);

        // Reset mid-packet with committed data pending
        do_reset();
        send_pkt(2, 0);
        repeat (2) tick();
        chk("midrst_pending", m_tvalid, 1);
        s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = rnd_data();
        tick();
        rst_n = 1'b0; s_tvalid = 1'b0;
        #1;
        chk("midrst_async", m_tvalid, 0);
        tick();
        chk("midrst_tvalid", m_tvalid, 0);
        chk("midrst_beat", m_beat, 0);
        rst_n = 1'b1; rcvd = 0;
        send_pkt(2, 1);
        drain(20);
        chk("midrst_beats_out", rcvd, 2);

        // Random packets and random tready, kept well below the pause threshold
        do_reset();
        begin
            int sent = 0, rem = 0, pkts = 0;
            for (int cyc = 0; cyc < 4000 && (pkts < 60 || rem != 0); cyc++) begin
                m_tready = 1'($urandom_range(0, 1));
                if (rem == 0 && pkts < 60 && $urandom_range(0, 3) != 0) begin
                    rem = $urandom_range(1, 5);
                    pkts++;
                end
                if (rem != 0 && sent - rcvd < 8 && $urandom_range(0, 4) != 0) begin
                    s_tvalid = 1'b1; s_tlast = (rem == 1); s_tkeep = 14'($urandom); s_tdata = rnd_data();
                    exp_q.push_back({s_tlast, s_tkeep, s_tdata});
                    rem--; sent++;
                end else begin
                    s_tvalid = 1'b0; s_tlast = 1'b0;
                end
                tick();
                chk("rand_pause_low", pause_req, 0);
            end
            chk("rand_all_sent", rem, 0);
            drain(100);
            chk("rand_beats_out", rcvd, sent);
            chk("rand_no_overflow", ovf_cnt, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
